// File: rtl/riscv_cpu_pkg.sv
// Shared LSU types: access-size enum, tracked-transaction record and defaults.
package riscv_cpu_pkg;

  typedef enum logic [1:0] {
    LSU_BYTE   = 2'b00,
    LSU_HALF   = 2'b01,
    LSU_WORD   = 2'b10,
    LSU_DOUBLE = 2'b11
  } lsu_data_type_e;

  // Offset field is sized for the widest (64-bit) bus so one record fits both widths.
  localparam int LSU_OFF_MAX_W = 3;
  localparam int LSU_MAX_OUTSTANDING_DEFAULT = 2;

  typedef struct packed {
    logic                     we;
    lsu_data_type_e           data_type;
    logic                     sign_ext;
    logic [LSU_OFF_MAX_W-1:0] offset;
    logic                     err;
  } lsu_txn_t;

  function automatic logic [3:0] lsu_size_bytes(lsu_data_type_e t);
    return 4'd1 << t;
  endfunction

endpackage

// File: rtl/lsu_txn_fifo.sv
// In-order tracking FIFO for outstanding LSU bus transactions.
module lsu_txn_fifo
  import riscv_cpu_pkg::*;
#(
  parameter int DEPTH = LSU_MAX_OUTSTANDING_DEFAULT,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  lsu_txn_t         push_data,
  input  logic             pop,
  output lsu_txn_t         head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  lsu_txn_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  assign head    = mem[rd_ptr_reg];

  function automatic logic [PTR_W-1:0] ptr_inc(logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_en)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/lsu_pipelined.sv
// Pipelined req/gnt/rvalid load-store unit with in-order tracking.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_pipelined
  import riscv_cpu_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = LSU_MAX_OUTSTANDING_DEFAULT,
  localparam int BE_W  = DATA_WIDTH / 8,
  localparam int OFF_W = $clog2(BE_W),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  mem_req_i,
  output logic                  mem_gnt_o,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_data_type_i,
  input  logic                  mem_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic                  mem_rvalid_o,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_err_o,
  output logic                  busy_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [BE_W-1:0]       data_be_o,
  output logic [DATA_WIDTH-1:0] data_wdata_o,
  input  logic [DATA_WIDTH-1:0] data_rdata_i
);

  lsu_data_type_e   req_type;
  logic [OFF_W-1:0] req_off;
  logic [3:0]       req_bytes;
  logic             trap_block;
  logic             trap_accept;
  logic             push;
  logic             pop_en;
  lsu_txn_t         push_data;
  lsu_txn_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_next;

  logic                  rvalid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  err_reg;
  logic                  busy_reg;

  // A double request on a 32-bit bus is handled as a word.
  always_comb begin
    req_type = lsu_data_type_e'(mem_data_type_i);
    if (DATA_WIDTH == 32 && req_type == LSU_DOUBLE) req_type = LSU_WORD;
  end

  assign req_off   = mem_addr_i[OFF_W-1:0];
  assign req_bytes = lsu_size_bytes(req_type);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  always_comb begin
    misaligned = 1'b0;
    case (req_type)
      LSU_HALF:   misaligned = mem_addr_i[0];
      LSU_WORD:   misaligned = |mem_addr_i[1:0];
      LSU_DOUBLE: misaligned = |mem_addr_i[2:0];
      default:    misaligned = 1'b0;
    endcase
  end
  // Misaligned requests never reach the bus; they wait for a drained FIFO to keep order.
  assign trap_block  = misaligned;
  assign trap_accept = mem_req_i & misaligned & fifo_empty;
`else
  assign trap_block  = 1'b0;
  assign trap_accept = 1'b0;
`endif

  assign data_req_o  = mem_req_i & ~fifo_full & ~trap_block;
  assign push        = data_req_o & data_gnt_i;
  assign mem_gnt_o   = push | trap_accept;
  assign data_addr_o = {mem_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign data_we_o   = mem_we_i;

  for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
    assign data_be_o[gi] = (gi >= int'(req_off)) && (gi < int'(req_off) + int'(req_bytes));
    assign data_wdata_o[8*gi +: 8] =
      (req_type == LSU_BYTE) ? mem_wdata_i[7:0] :
      (req_type == LSU_HALF) ? mem_wdata_i[8*(gi%2) +: 8] :
      (req_type == LSU_WORD) ? mem_wdata_i[8*(gi%4) +: 8] :
                               mem_wdata_i[8*gi +: 8];
  end

  always_comb begin
    push_data           = '0;
    push_data.we        = mem_we_i;
    push_data.data_type = req_type;
    push_data.sign_ext  = mem_sign_ext_i;
    push_data.offset    = LSU_OFF_MAX_W'(req_off);
    push_data.err       = 1'b0;
  end

  lsu_txn_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (data_rvalid_i),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Responses with nothing outstanding (e.g. stale beats after reset) are dropped.
  assign pop_en     = data_rvalid_i & ~fifo_empty;
  assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop_en);

  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_val;
  logic                  sign_bit;
  int                    rsp_bits;

  assign shifted = data_rdata_i >> {head.offset, 3'b000};

  always_comb begin
    load_val = shifted;
    rsp_bits = 8 << head.data_type;
    case (head.data_type)
      LSU_BYTE: sign_bit = shifted[7];
      LSU_HALF: sign_bit = shifted[15];
      LSU_WORD: sign_bit = shifted[31];
      default:  sign_bit = shifted[DATA_WIDTH-1];
    endcase
    for (int b = 8; b < DATA_WIDTH; b++) begin
      if (b >= rsp_bits) load_val[b] = head.sign_ext & sign_bit;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      rvalid_reg <= pop_en | trap_accept;
      rdata_reg  <= (pop_en & ~head.we) ? load_val : '0;
      err_reg    <= trap_accept | (pop_en & head.err);
      busy_reg   <= (count_next != '0);
    end
  end

  assign mem_rvalid_o = rvalid_reg;
  assign mem_rdata_o  = rdata_reg;
  assign mem_err_o    = err_reg;
  assign busy_o       = busy_reg;

endmodule

// File: doc/lsu_pipelined.md
# lsu_pipelined

Parametrised load-store unit for the MEM stage. It replaces the single-transaction simple LSU with a pipelined request/grant/rvalid bus master that supports:
- up to `MAX_OUTSTANDING` in-order transactions,
- byte/half/word (and double on 64-bit) accesses with byte enables,
- write-data replication and load sign/zero extension.

It sits between the MEM stage's memory request signals and the data memory port.

## Interface
Parameters:
- `DATA_WIDTH`, 32 — bus data width; legal values 32 or 64; `BE_W = DATA_WIDTH/8`, `OFF_W = $clog2(BE_W)`.
- `ADDR_WIDTH`, 32 — address width.
- `MAX_OUTSTANDING`, 2 — transaction-tracking FIFO depth; power of two, ≥1.

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `mem_req_i`  in  1  core request valid.
- `mem_gnt_o`  out  1  core request accepted this cycle.
- `mem_we_i`  in  1  1 = store.
- `mem_data_type_i`  in  2  00 byte, 01 half, 10 word, 11 double (treated as word when `DATA_WIDTH=32`).
- `mem_sign_ext_i`  in  1  sign-extend load result.
- `mem_addr_i`  in  `ADDR_WIDTH`  byte address.
- `mem_wdata_i`  in  `DATA_WIDTH`  store data, LSB-aligned.
- `mem_rvalid_o`  out  1  response valid (loads and stores).
- `mem_rdata_o`  out  `DATA_WIDTH`  aligned, extended load data; 0 for stores.
- `mem_err_o`  out  1  misaligned-access error; qualified by `mem_rvalid_o`.
- `busy_o`  out  1  at least one transaction outstanding.
- `data_req_o`  out  1  bus request.
- `data_gnt_i`  in  1  bus grant.
- `data_rvalid_i`  in  1  bus response valid, in order.
- `data_addr_o`  out  `ADDR_WIDTH`  bus address, aligned to `BE_W` bytes.
- `data_we_o`  out  1  bus write.
- `data_be_o`  out  `BE_W`  byte enables.
- `data_wdata_o`  out  `DATA_WIDTH`  replicated store data.
- `data_rdata_i`  in  `DATA_WIDTH`  bus read data.

## Operation
- **Issue** (combinational):
  - `data_req_o = mem_req_i & ~fifo_full & ~trap_block`.
  - `mem_gnt_o = data_req_o & data_gnt_i`, or a trap accept (see Configuration).
  - Address, we, be and wdata are driven combinationally from the core inputs.
- **Byte enables:** size mask (byte 1, half 3, word 0xF, double 0xFF), shifted left by `addr[OFF_W-1:0]`, truncated to `BE_W` bits.
- **Write data:** byte replicated `BE_W` times; half replicated `BE_W/2` times; word replicated twice on 64-bit; double passed through.
- **Tracking:** on each bus handshake (`data_req_o & data_gnt_i`), push `{we, type, sign_ext, offset, err=0}` into the FIFO. Pop on `data_rvalid_i`.
- **Response path:**
  - `data_rdata_i` is right-shifted by `offset*8`, then masked to the access size.
  - If `sign_ext`, bit 7/15/31 is replicated upward; otherwise zero-filled.
  - Stores return `rdata = 0`.
  - The result is registered.
- **Full FIFO:** no new request, even if a pop occurs the same cycle.
- **Empty FIFO:** a `data_rvalid_i` arriving with an empty FIFO is ignored (e.g. after reset mid-operation).
- **Simultaneous push and pop on a non-full FIFO:** both take effect; the count is unchanged.
- **Pointers** wrap modulo `MAX_OUTSTANDING`. The occupancy counter is `$clog2(MAX_OUTSTANDING)+1` bits wide.

## Timing
- **Reset values:** `mem_rvalid_o=0`, `mem_rdata_o=0`, `mem_err_o=0`, `busy_o=0`. FIFO is empty with pointers at 0. Combinational outputs follow their inputs.
- **Request:** zero-cycle pass-through; a grant in cycle N pushes the FIFO at the edge ending N.
- **Response latency:** `data_rvalid_i` in cycle N → `mem_rvalid_o` in cycle N+1, for exactly one cycle per transaction.
- **`busy_o`:** registered, equal to `count != 0`.
- **Reset mid-operation:** all outstanding transactions are discarded; no responses are produced for them.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Misaligned access** (any of the following):
  - half with `addr[0]`;
  - word with `addr[1:0]≠0`;
  - double with `addr[2:0]≠0`.
- **Defined:**
  - A misaligned request is held (`mem_gnt_o=0`, `trap_block=1`) until the FIFO is empty.
  - It is then accepted with `mem_gnt_o=1` and `data_req_o=0`.
  - The next cycle produces `mem_rvalid_o=1`, `mem_err_o=1`, `mem_rdata_o=0`.
- **Undefined:**
  - Misaligned requests issue normally with truncated byte enables; the out-of-word bytes are dropped.
  - `mem_err_o` is tied to 0.

## Structure
- **Shared package `riscv_cpu_pkg`:**
  - `lsu_data_type_e` (BYTE, HALF, WORD, DOUBLE);
  - `lsu_txn_t` (we, type, sign_ext, offset, err);
  - `LSU_MAX_OUTSTANDING_DEFAULT`.
- **Sub-module `lsu_txn_fifo`:** parametrised synchronous FIFO of `lsu_txn_t` with full, empty and count outputs. Instantiated once.

## Test plan
- **Word store, addr 0x100, data 0xDEADBEEF, immediate grant:** `data_be_o=0xF`, `data_addr_o=0x100`; `data_rvalid_i` in the next cycle → `mem_rvalid_o` one cycle later with `rdata=0`.
- **Byte load from 0x103, sign-ext, bus returns 0x80FFFFFF:** `mem_rdata_o=0xFFFFFF80`. The same access with zero-extend → `0x00000080`.
- **Half store 0x1234 to 0x102:** `data_be_o=0xC`, `data_wdata_o=0x12341234`.
- **`MAX_OUTSTANDING=2`, three back-to-back loads, no rvalid:** third request sees `mem_gnt_o=0` and `busy_o=1`. When rvalid arrives the same cycle as the third request, the third is still blocked; it is granted the following cycle. Responses return in order.
- **Word load at 0x101 with `LSU_MISALIGN_TRAP_EN`, one load outstanding:** stalled until the outstanding response returns, then accepted with no bus request. `mem_err_o=1` arrives one cycle later.
- **Reset asserted with 2 transactions outstanding, then 2 late `data_rvalid_i` pulses:** `mem_rvalid_o` stays 0 and `busy_o=0`.
